// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder: one full-adder cell (two half-adders) plus a carry flop,
// consuming one operand bit per clock from LSB to MSB behind a start/busy/done handshake.
module serial_adder #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int unsigned CntW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CntW-1:0] LastBit = CntW'(WIDTH - 1);

    typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic             carry_q, carry_d;
    logic             cout_q, cout_d;

    logic ha0_s, ha0_c, ha1_c, bit_s, bit_c;

    // Full-adder cell built from two cascaded half-adders with their carries ORed.
    always_comb begin
        ha0_s = a_q[0] ^ b_q[0];
        ha0_c = a_q[0] & b_q[0];
        bit_s = ha0_s ^ carry_q;
        ha1_c = ha0_s & carry_q;
        bit_c = ha0_c | ha1_c;
    end

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        acc_d   = acc_q;
        sum_d   = sum_q;
        cnt_d   = cnt_q;
        carry_d = carry_q;
        cout_d  = cout_q;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    a_d     = a;
                    b_d     = b;
                    carry_d = cin;
                    cnt_d   = '0;
                    acc_d   = '0;
                    state_d = StShift;
                end
            end
            StShift: begin
                carry_d = bit_c;
                a_d     = {1'b0, a_q[WIDTH-1:1]};
                b_d     = {1'b0, b_q[WIDTH-1:1]};
                acc_d   = {bit_s, acc_q[WIDTH-1:1]};
                cnt_d   = cnt_q + 1'b1;
                if (cnt_q == LastBit) begin
                    sum_d   = {bit_s, acc_q[WIDTH-1:1]};
                    cout_d  = bit_c;
                    cnt_d   = cnt_q;
                    state_d = StDone;
                end
            end
            StDone: state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= StIdle;
            a_q     <= '0;
            b_q     <= '0;
            acc_q   <= '0;
            sum_q   <= '0;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            acc_q   <= acc_d;
            sum_q   <= sum_d;
            cnt_q   <= cnt_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
        end
    end

    assign busy = (state_q == StShift);
    assign done = (state_q == StDone);
    assign sum  = sum_q;
    assign cout = cout_q;

endmodule

// File: tb/tb_serial_adder.sv
// Randomized bench for serial_adder against a plain-arithmetic reference (a+b+cin).
module tb_serial_adder;

    localparam int unsigned W = 8;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         cin = 1'b0;
    logic         busy, done, cout;
    logic [W-1:0] sum;

    int unsigned  n_checks = 0;
    int unsigned  n_errors = 0;
    logic [W-1:0] prev_sum = '0;
    logic         prev_cout = 1'b0;

    always #5 clk = ~clk;

    serial_adder #(.WIDTH(W)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .a     (a),
        .b     (b),
        .cin   (cin),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // One full transaction; optionally re-pulses start with other operands mid-SHIFT.
    task automatic run_op(input logic [W-1:0] oa, input logic [W-1:0] ob, input logic oc,
                          input bit repulse);
        logic [W:0] exp;
        exp = {1'b0, oa} + {1'b0, ob} + {{W{1'b0}}, oc};
        @(negedge clk);
        start = 1'b1; a = oa; b = ob; cin = oc;
        @(negedge clk);
        start = 1'b0; a = W'($urandom); b = W'($urandom); cin = 1'($urandom);
        check("busy_accept", 32'(busy), 32'd1);
        check("done_accept", 32'(done), 32'd0);
        check("sum_hold0", 32'(sum), 32'(prev_sum));
        for (int k = 1; k < int'(W); k++) begin
            if (repulse && k == 2) begin
                start = 1'b1; a = ~oa; b = oa; cin = ~oc;
            end
            @(negedge clk);
            start = 1'b0;
            check("busy_shift", 32'(busy), 32'd1);
            check("done_shift", 32'(done), 32'd0);
            check("sum_hold", 32'(sum), 32'(prev_sum));
            check("cout_hold", 32'(cout), 32'(prev_cout));
        end
        @(negedge clk);
        check("done_pulse", 32'(done), 32'd1);
        check("busy_done", 32'(busy), 32'd0);
        check("sum", 32'(sum), 32'(exp[W-1:0]));
        check("cout", 32'(cout), 32'(exp[W]));
        prev_sum  = exp[W-1:0];
        prev_cout = exp[W];
        @(negedge clk);
        check("done_clear", 32'(done), 32'd0);
        check("busy_idle", 32'(busy), 32'd0);
        check("sum_idle", 32'(sum), 32'(prev_sum));
    endtask

    task automatic wait_done(output int cycles);
        cycles = 0;
        for (int i = 0; i < 4 * int'(W); i++) begin
            @(negedge clk);
            cycles++;
            if (done) break;
        end
        if (!done) check("done_timeout", 32'd0, 32'd1);
    endtask

    initial begin
        int n;
        logic [W:0] e;

        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_sum", 32'(sum), 32'd0);
        check("rst_cout", 32'(cout), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        rst_n = 1'b1;

        run_op(8'h00, 8'h00, 1'b0, 1'b0);
        run_op(8'hFF, 8'h01, 1'b0, 1'b0);
        run_op(8'hA5, 8'h5A, 1'b1, 1'b0);
        run_op(8'h7F, 8'h01, 1'b0, 1'b0);
        run_op(8'h3C, 8'h81, 1'b1, 1'b1);

        // Abort during bit 3 of 0x12+0x34; prior result 0x3C+0x81+1=0xBE must be cleared.
        @(negedge clk);
        start = 1'b1; a = 8'h12; b = 8'h34; cin = 1'b0;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        check("abort_sum", 32'(sum), 32'd0);
        check("abort_cout", 32'(cout), 32'd0);
        rst_n = 1'b1;
        prev_sum = '0;
        prev_cout = 1'b0;

        // start held high across back-to-back operations.
        @(negedge clk);
        start = 1'b1; a = 8'h11; b = 8'h22; cin = 1'b0;
        wait_done(n);
        check("held_lat1", 32'(n), 32'(W + 1));
        check("held_sum1", 32'(sum), 32'h33);
        a = 8'hF0; b = 8'h15; cin = 1'b1;
        wait_done(n);
        check("held_lat2", 32'(n), 32'(W + 2));
        check("held_sum2", 32'(sum), 32'h06);
        check("held_cout2", 32'(cout), 32'd1);
        start = 1'b0;
        @(negedge clk);
        e = 9'h106;
        prev_sum = e[W-1:0];
        prev_cout = e[W];

        for (int i = 0; i < 20; i++) begin
            run_op(W'($urandom), W'($urandom), 1'($urandom), (i % 5) == 4);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
